// File: rtl/fib_engine_if.sv
// rtl/fib_engine_if.sv - request/response bundle between a requester and fib_engine
interface fib_engine_if #(
  parameter int WIDTH = 64,
  parameter int IDX_W = 8
);
  logic [1:0]              op;
  logic [WIDTH-1:0]        number;
  logic                    valid;
  logic                    ready;
  logic signed [IDX_W-1:0] index;
  logic [WIDTH-1:0]        value;
  logic                    hit;
  logic                    overflow;
  logic                    index_valid;
  logic                    index_ready;

  modport master (
    output op, number, valid, index_ready,
    input  ready, index, value, hit, overflow, index_valid
  );

  modport slave (
    input  op, number, valid, index_ready,
    output ready, index, value, hit, overflow, index_valid
  );
endinterface

// File: rtl/fib_engine.sv
// rtl/fib_engine.sv - iterative Fibonacci engine: exact index, floor index and nth value
module fib_engine #(
  parameter int WIDTH = 64,
  parameter int IDX_W = 8
) (
  input  logic         clk,
  input  logic         rst,
  fib_engine_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [1:0]       op_q, op_d;
  logic [WIDTH-1:0] number_q, number_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [IDX_W-1:0] k_q, k_d;
  logic             bovf_q, bovf_d;
  logic [IDX_W-1:0] index_q, index_d;
  logic [WIDTH-1:0] value_q, value_d;
  logic             hit_q, hit_d;
  logic             overflow_q, overflow_d;
  logic             index_valid_q, index_valid_d;

  logic [IDX_W-1:0] n_sel;
  logic [WIDTH:0]   sum;
  logic             finish;
  logic [IDX_W-1:0] res_index;
  logic [WIDTH-1:0] res_value;
  logic             res_hit;
  logic             res_overflow;

  assign n_sel = {1'b0, number_q[IDX_W-2:0]};
  assign sum   = {1'b0, a_q} + {1'b0, b_q};

  assign bus.ready       = (state_q == IDLE);
  assign bus.index       = index_q;
  assign bus.value       = value_q;
  assign bus.hit         = hit_q;
  assign bus.overflow    = overflow_q;
  assign bus.index_valid = index_valid_q;

  always_comb begin
    state_d       = state_q;
    op_d          = op_q;
    number_d      = number_q;
    a_d           = a_q;
    b_d           = b_q;
    k_d           = k_q;
    bovf_d        = bovf_q;
    index_d       = index_q;
    value_d       = value_q;
    hit_d         = hit_q;
    overflow_d    = overflow_q;
    index_valid_d = index_valid_q;
    finish        = 1'b0;
    res_index     = '1;
    res_value     = '0;
    res_hit       = 1'b0;
    res_overflow  = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.valid) begin
          op_d     = bus.op;
          number_d = bus.number;
          a_d      = '0;
          b_d      = WIDTH'(1);
          k_d      = '0;
          bovf_d   = 1'b0;
          state_d  = RUN;
        end
      end
      RUN: begin
        // a = F(k), b = F(k+1); bovf flags that b no longer fits in WIDTH bits
        case (op_q)
          2'b00: begin
            if (a_q == number_q) begin
              finish    = 1'b1;
              res_index = k_q;
              res_value = a_q;
              res_hit   = 1'b1;
            end else if (a_q > number_q || bovf_q) begin
              finish = 1'b1;
            end
          end
          2'b01: begin
            if (bovf_q || b_q > number_q) begin
              finish    = 1'b1;
              res_index = k_q;
              res_value = a_q;
              res_hit   = 1'b1;
            end
          end
          2'b10: begin
            if (k_q == n_sel) begin
              finish    = 1'b1;
              res_index = k_q;
              res_value = a_q;
              res_hit   = 1'b1;
            end else if (bovf_q) begin
              finish       = 1'b1;
              res_index    = n_sel;
              res_value    = '1;
              res_overflow = 1'b1;
            end
          end
          default: finish = 1'b1;
        endcase

        if (finish) begin
          state_d    = DONE;
          index_d    = res_index;
          value_d    = res_value;
          hit_d      = res_hit;
          overflow_d = res_overflow;
        end else begin
          a_d    = b_q;
          b_d    = sum[WIDTH-1:0];
          bovf_d = sum[WIDTH];
          k_d    = k_q + IDX_W'(1);
        end
      end
      DONE: begin
        // Result registers settle on DONE entry; valid is presented one cycle later.
        if (!index_valid_q) begin
          index_valid_d = 1'b1;
        end else if (bus.index_ready) begin
          index_valid_d = 1'b0;
          state_d       = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= IDLE;
      op_q          <= '0;
      number_q      <= '0;
      a_q           <= '0;
      b_q           <= '0;
      k_q           <= '0;
      bovf_q        <= 1'b0;
      index_q       <= '0;
      value_q       <= '0;
      hit_q         <= 1'b0;
      overflow_q    <= 1'b0;
      index_valid_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      op_q          <= op_d;
      number_q      <= number_d;
      a_q           <= a_d;
      b_q           <= b_d;
      k_q           <= k_d;
      bovf_q        <= bovf_d;
      index_q       <= index_d;
      value_q       <= value_d;
      hit_q         <= hit_d;
      overflow_q    <= overflow_d;
      index_valid_q <= index_valid_d;
    end
  end

endmodule

// File: tb/tb_fib_engine.sv
// tb/tb_fib_engine.sv - scoreboard bench for fib_engine at WIDTH=64 and WIDTH=16
module tb_fib_engine;

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_fail = 0;
  bit   rnd_rdy = 1'b0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  fib_engine_if #(.WIDTH(64), .IDX_W(8)) bus64 ();
  fib_engine_if #(.WIDTH(16), .IDX_W(8)) bus16 ();

  fib_engine #(.WIDTH(64), .IDX_W(8)) dut64 (.clk(clk), .rst(rst), .bus(bus64.slave));
  fib_engine #(.WIDTH(16), .IDX_W(8)) dut16 (.clk(clk), .rst(rst), .bus(bus16.slave));

  typedef struct {
    logic [7:0]  idx;
    logic [63:0] val;
    logic        hit;
    logic        ovf;
    int          lat;
    int          acc;
  } exp_t;

  exp_t q64[$];
  exp_t q16[$];

  function automatic logic [127:0] fibv(input int k);
    logic [127:0] x = 128'd0;
    logic [127:0] y = 128'd1;
    logic [127:0] t;
    for (int i = 0; i < k; i++) begin
      t = x + y;
      x = y;
      y = t;
    end
    return x;
  endfunction

  // Reference: search the sequence directly, with values limited to w bits.
  function automatic exp_t model(input int w, input logic [1:0] op, input logic [63:0] num);
    logic [127:0] f[0:127];
    logic [127:0] lim;
    logic [127:0] nm;
    logic [127:0] ones;
    int kmax;
    int k;
    int n;
    exp_t e;
    f[0] = 128'd0;
    f[1] = 128'd1;
    for (int i = 2; i < 128; i++) f[i] = f[i-1] + f[i-2];
    lim  = 128'd1 << w;
    ones = lim - 128'd1;
    nm   = {64'd0, num} & ones;
    kmax = 0;
    for (int i = 0; i < 128; i++) if (f[i] < lim) kmax = i;
    e.idx = 8'hFF; e.val = 64'd0; e.hit = 1'b0; e.ovf = 1'b0; e.lat = 2; e.acc = 0;
    case (op)
      2'b00: begin
        k = 0;
        while (k < kmax && f[k] < nm) k++;
        if (f[k] == nm) begin
          e.idx = 8'(k); e.val = f[k][63:0]; e.hit = 1'b1;
        end
        e.lat = k + 2;
      end
      2'b01: begin
        k = 0;
        for (int i = 0; i <= kmax; i++) if (f[i] <= nm) k = i;
        e.idx = 8'(k); e.val = f[k][63:0]; e.hit = 1'b1; e.lat = k + 2;
      end
      2'b10: begin
        n = int'(nm[6:0]);
        e.idx = 8'(n);
        if (n <= kmax) begin
          e.val = f[n][63:0]; e.hit = 1'b1; e.lat = n + 2;
        end else begin
          e.val = ones[63:0]; e.ovf = 1'b1; e.lat = kmax + 2;
        end
      end
      default: e.lat = 2;
    endcase
    return e;
  endfunction

  function automatic exp_t mk(input int idx, input logic [63:0] val, input bit h, input bit o,
                              input int lat);
    exp_t e;
    e.idx = 8'(idx); e.val = val; e.hit = h; e.ovf = o; e.lat = lat; e.acc = 0;
    return e;
  endfunction

  task automatic cmp(input string name, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: actual %0h required %0h", name, act, req);
    end
  endtask

  task automatic check_out(input int sel, input logic [7:0] idx, input logic [63:0] val,
                           input logic h, input logic o, input int rise);
    exp_t  e;
    string pre;
    pre = (sel != 0) ? "w16" : "w64";
    if ((sel == 0 && q64.size() == 0) || (sel != 0 && q16.size() == 0)) begin
      n_cmp++;
      n_fail++;
      $display("FAIL %s_unexpected: actual result index %0d required none", pre, $signed(idx));
      return;
    end
    e = (sel != 0) ? q16.pop_front() : q64.pop_front();
    cmp({pre, "_index"}, {56'd0, idx}, {56'd0, e.idx});
    cmp({pre, "_value"}, val, e.val);
    cmp({pre, "_hit"}, {63'd0, h}, {63'd0, e.hit});
    cmp({pre, "_overflow"}, {63'd0, o}, {63'd0, e.ovf});
    cmp({pre, "_latency"}, 64'(rise - e.acc), 64'(e.lat));
  endtask

  int   rise64, rise16;
  logic v64_prev = 1'b0;
  logic v16_prev = 1'b0;

  always @(negedge clk) begin
    if (!rst) begin
      v64_prev = 1'b0;
    end else begin
      if (bus64.index_valid && !v64_prev) rise64 = cyc;
      v64_prev = bus64.index_valid;
      if (bus64.index_valid && bus64.index_ready)
        check_out(0, bus64.index, bus64.value, bus64.hit, bus64.overflow, rise64);
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      v16_prev = 1'b0;
    end else begin
      if (bus16.index_valid && !v16_prev) rise16 = cyc;
      v16_prev = bus16.index_valid;
      if (bus16.index_valid && bus16.index_ready)
        check_out(1, bus16.index, {48'd0, bus16.value}, bus16.hit, bus16.overflow, rise16);
    end
  end

  always @(posedge clk) begin
    #2;
    if (rnd_rdy) begin
      bus64.index_ready = 1'($urandom_range(0, 1));
      bus16.index_ready = 1'($urandom_range(0, 1));
    end
  end

  // Called at posedge+2; the request is accepted on the following edge.
  task automatic send(input int sel, input logic [1:0] op, input logic [63:0] num, input exp_t e);
    int t = 0;
    while (!((sel != 0) ? bus16.ready : bus64.ready) && t < 500) begin
      @(posedge clk); #2;
      t++;
    end
    if (t >= 500) begin
      n_cmp++;
      n_fail++;
      $display("FAIL send_timeout: actual ready 0 required 1 (sel %0d)", sel);
      return;
    end
    e.acc = cyc + 1;
    if (sel != 0) begin
      bus16.op = op; bus16.number = num[15:0]; bus16.valid = 1'b1;
      q16.push_back(e);
    end else begin
      bus64.op = op; bus64.number = num; bus64.valid = 1'b1;
      q64.push_back(e);
    end
    @(posedge clk); #2;
    bus16.valid = 1'b0;
    bus64.valid = 1'b0;
  endtask

  task automatic drain();
    int t = 0;
    while ((q64.size() != 0 || q16.size() != 0) && t < 5000) begin
      @(posedge clk); #2;
      t++;
    end
    if (t >= 5000) begin
      n_cmp++;
      n_fail++;
      $display("FAIL drain_timeout: actual pending %0d required 0", q64.size() + q16.size());
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: actual cycle %0d required completion", cyc);
    $fatal(1);
  end

  localparam logic [63:0] F93 = 64'hA94FAD42221F2702;

  initial begin
    int   nums[11]  = '{0, 1, 2, 3, 4, 5, 20, 21, 22, 88, 89};
    int   idxs[11]  = '{0, 1, 3, 4, -1, 5, -1, 8, -1, -1, 11};
    int   vals[11]  = '{0, 1, 2, 3, 0, 5, 0, 21, 0, 0, 89};
    int   lats[11]  = '{2, 3, 5, 6, 7, 7, 10, 10, 11, 13, 13};
    int   t;
    int   sel;
    logic [1:0]   op;
    logic [63:0]  num;
    logic [127:0] fv;

    rst = 1'b0;
    bus64.valid = 1'b0; bus64.op = 2'b00; bus64.number = '0; bus64.index_ready = 1'b1;
    bus16.valid = 1'b0; bus16.op = 2'b00; bus16.number = '0; bus16.index_ready = 1'b1;
    repeat (3) @(posedge clk);
    #2;
    cmp("rst_ready", {63'd0, bus64.ready}, 64'd1);
    cmp("rst_index_valid", {63'd0, bus64.index_valid}, 64'd0);
    cmp("rst_index", {56'd0, bus64.index}, 64'd0);
    cmp("rst_value", bus64.value, 64'd0);
    cmp("rst_hit", {63'd0, bus64.hit}, 64'd0);
    cmp("rst_overflow", {63'd0, bus64.overflow}, 64'd0);
    rst = 1'b1;
    @(posedge clk); #2;

    for (int i = 0; i < 11; i++)
      send(0, 2'b00, 64'(nums[i]), mk(idxs[i], 64'(vals[i]), idxs[i] >= 0, 1'b0, lats[i]));
    send(0, 2'b00, F93, mk(93, F93, 1'b1, 1'b0, 95));
    send(0, 2'b00, F93 - 64'd1, mk(-1, 64'd0, 1'b0, 1'b0, 95));
    send(0, 2'b01, 64'd20, mk(7, 64'd13, 1'b1, 1'b0, 9));
    send(0, 2'b01, 64'd1, mk(2, 64'd1, 1'b1, 1'b0, 4));
    send(0, 2'b01, '1, mk(93, F93, 1'b1, 1'b0, 95));
    send(0, 2'b11, 64'd5, mk(-1, 64'd0, 1'b0, 1'b0, 2));
    send(1, 2'b10, 64'd24, mk(24, 64'd46368, 1'b1, 1'b0, 26));
    send(1, 2'b10, 64'd25, mk(25, 64'hFFFF, 1'b0, 1'b1, 26));
    send(1, 2'b10, 64'd0, mk(0, 64'd0, 1'b1, 1'b0, 2));
    drain();

    rnd_rdy = 1'b1;
    for (int i = 0; i < 60; i++) begin
      sel = int'($urandom_range(0, 1));
      op  = 2'($urandom_range(0, 3));
      case ($urandom_range(0, 2))
        0: num = 64'($urandom_range(0, 300));
        1: begin
          fv  = fibv(int'($urandom_range(0, 100)));
          num = fv[63:0] + 64'($urandom_range(0, 2)) - 64'd1;
        end
        default: num = {$urandom, $urandom};
      endcase
      send(sel, op, num, model((sel != 0) ? 16 : 64, op, num));
    end
    drain();
    rnd_rdy = 1'b0;
    @(posedge clk); #2;

    bus64.index_ready = 1'b0;
    bus16.index_ready = 1'b1;
    send(0, 2'b00, 64'd89, mk(11, 64'd89, 1'b1, 1'b0, 13));
    t = 0;
    while (!bus64.index_valid && t < 200) begin
      @(posedge clk); #2;
      t++;
    end
    for (int i = 0; i < 10; i++) begin
      bus64.valid = 1'b1; bus64.op = 2'b10; bus64.number = 64'd5;
      cmp("bp_index_valid", {63'd0, bus64.index_valid}, 64'd1);
      cmp("bp_ready", {63'd0, bus64.ready}, 64'd0);
      cmp("bp_index", {56'd0, bus64.index}, 64'd11);
      cmp("bp_value", bus64.value, 64'd89);
      @(posedge clk); #2;
    end
    bus64.valid = 1'b0;
    bus64.index_ready = 1'b1;
    @(posedge clk); #2;
    cmp("bp_release_valid", {63'd0, bus64.index_valid}, 64'd0);
    cmp("bp_release_ready", {63'd0, bus64.ready}, 64'd1);
    repeat (5) @(posedge clk);
    #2;
    cmp("bp_no_extra_result", {63'd0, bus64.index_valid}, 64'd0);
    cmp("bp_queue_empty", 64'(q64.size()), 64'd0);

    bus64.op = 2'b10; bus64.number = 64'd50; bus64.valid = 1'b1;
    @(posedge clk); #2;
    bus64.valid = 1'b0;
    repeat (20) @(posedge clk);
    #3;
    cmp("mid_run_busy", {63'd0, bus64.ready}, 64'd0);
    rst = 1'b0;
    #1;
    cmp("mid_rst_ready", {63'd0, bus64.ready}, 64'd1);
    cmp("mid_rst_index_valid", {63'd0, bus64.index_valid}, 64'd0);
    cmp("mid_rst_index", {56'd0, bus64.index}, 64'd0);
    cmp("mid_rst_value", bus64.value, 64'd0);
    cmp("mid_rst_hit", {63'd0, bus64.hit}, 64'd0);
    cmp("mid_rst_overflow", {63'd0, bus64.overflow}, 64'd0);
    @(posedge clk); #2;
    rst = 1'b1;
    @(posedge clk); #2;
    send(0, 2'b10, 64'd50, mk(50, 64'd12586269025, 1'b1, 1'b0, 52));
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
